mem_wb_pipe: RTL
================

Name: mem_wb_pipe

Overview:
- Parametrised successor of the MEM/WB pipeline register. Carries memory-stage results to write-back through DEPTH register stages, to absorb multi-cycle data memory latency.
- Adds the following over a plain pipeline register:
  - per-entry valid bit
  - stall (hold) and flush (bubble insertion)
  - sub-word load extraction and sign/zero extension
  - final write-back data mux
  - register-0 write suppression
- Sits between the data-memory stage and the register file. Its write-back outputs also feed the forwarding unit.

Parameters:
- DATA_W, 32, datapath width in bits; must be 32 or 64.
- RA_W, 5, register-address width.
- DEPTH, 1, number of register stages (1..4). Latency from inputs to outputs equals DEPTH cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- Stall  in  1  hold all stages this cycle.
- Flush  in  1  convert all stages to bubbles this cycle.
- ValidIn  in  1  incoming entry is a real instruction.
- ALUResultIn  in  DATA_W  ALU result / memory address.
- ReadDataDMIn  in  DATA_W  raw data-memory word.
- MemToRegIn  in  1  select memory data for write-back.
- RegWriteIn  in  1  instruction writes the register file.
- WriteRegisterIn  in  RA_W  destination register.
- LoadTypeIn  in  3  0 word, 1 byte signed, 2 byte unsigned, 3 half signed, 4 half unsigned; 5..7 behave as word.
- Valid  out  1  output entry is valid.
- ALUResult  out  DATA_W  registered ALU result.
- ReadDataDM  out  DATA_W  registered raw memory word.
- MemToReg  out  1  registered select.
- RegWrite  out  1  qualified write enable.
- WriteRegister  out  RA_W  registered destination.
- WriteData  out  DATA_W  final write-back value.

Behaviour:
- Reset (async, rst=1): every stage's fields are cleared to 0, including valid. All outputs are 0 immediately, without waiting for a clock. Deassertion is sampled on the next rising edge.
- Structure: stages S[0..DEPTH-1]. Stage 0 captures the inputs; S[i] captures S[i-1]. Outputs come from S[DEPTH-1].
- Per rising edge, in priority order:
  1. Flush=1: all stages are zeroed, same as reset. The input entry is dropped. Flush wins over Stall.
  2. Stall=1: all stages hold their contents. Inputs are ignored.
  3. Otherwise: shift by one stage. S[0] takes ValidIn and all *In fields.
- Entry with ValidIn=0: still captured as presented, but RegWrite output is forced low while it is at the output.
- RegWrite = RegWrite_q AND Valid AND (WriteRegister != 0). The register-0 write is suppressed here, not in the register file.
- Lane select:
  - Byte lane index = ALUResult[log2(DATA_W/8)-1:0].
  - Halfword index = the same bits excluding bit 0.
  - Misaligned halfword (bit 0 set): use the lane containing bit 0 cleared.
- Extraction:
  - Signed types: the extracted field is sign-extended to DATA_W.
  - Unsigned types: the field is zero-extended.
  - Word type (DATA_W=64): returns the full 64-bit ReadDataDM.
- WriteData = MemToReg ? extended load data : ALUResult. Purely combinational from the output stage; no extra latency.
- ReadDataDM output is the raw registered word, not the extended value.
- Reset mid-stall or mid-flush: reset dominates asynchronously.
- Stall then flush in consecutive cycles: the held entries are discarded.

Decomposition:
- Shared package pipe_pkg holds:
  - LoadType encodings as named constants: LD_W, LD_B, LD_BU, LD_H, LD_HU
  - a packed struct of the stage fields (valid, alu, rdata, memtoreg, regwrite, wreg, ltype), parametrised via DATA_W/RA_W localparams
- One natural sub-module: load_ext, the combinational lane select and sign/zero extension. It is reused later by the store-alignment path.

Test Plan:
1. DEPTH=1, ValidIn=1, ALUResultIn=0x1000_0004, MemToRegIn=0, RegWriteIn=1, WriteRegisterIn=3 → next edge: WriteData=0x1000_0004, RegWrite=1, WriteRegister=3.
2. Load byte signed: ReadDataDMIn=0x12F4_5678, ALUResultIn[1:0]=2, LoadType=1, MemToReg=1 → WriteData=0xFFFF_FFF4. With LoadType=2 → 0x0000_00F4. With LoadType=4 and addr[1]=1 → 0x0000_12F4.
3. WriteRegisterIn=0, RegWriteIn=1, ValidIn=1 → RegWrite output stays 0. Separately, ValidIn=0 with WriteRegisterIn=7 → RegWrite=0.
4. DEPTH=3: stream entries A,B,C; assert Stall for 2 cycles after B enters → outputs unchanged during stall, A appears at the output exactly 3 unstalled edges after capture, order A,B,C preserved.
5. Stall and Flush both high with 3 valid entries in flight → after the edge, Valid=0, RegWrite=0, all outputs 0; the next entry emerges after DEPTH edges.
6. Assert rst asynchronously between edges while Valid=1 → all outputs go to 0 before the next clock edge; after release, the first captured entry appears after DEPTH edges.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline: load-type encodings and the stage record.
// The stage record is sized for the widest supported datapath; narrower instances use the low bits.
package pipe_pkg;

    localparam int PKG_DATA_W = 64;
    localparam int PKG_RA_W   = 8;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef struct packed {
        logic                  valid;
        logic [PKG_DATA_W-1:0] alu;
        logic [PKG_DATA_W-1:0] rdata;
        logic                  memtoreg;
        logic                  regwrite;
        logic [PKG_RA_W-1:0]   wreg;
        logic [2:0]            ltype;
    } stage_t;

    function automatic logic ld_is_signed(input logic [2:0] ltype);
        return (ltype == LD_B) || (ltype == LD_H);
    endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational lane select and sign/zero extension of a raw data-memory word.
// A misaligned halfword address falls back to the halfword lane containing it.
module load_ext
    import pipe_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic [2:0]        ltype_i,
    output logic [DATA_W-1:0] data_o
);

    logic [LANE_W-2:0] half_idx;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic              sext;

    assign half_idx = lane_i[LANE_W-1:1];

    always_comb begin
        byte_v = rdata_i[{lane_i, 3'b000} +: 8];
        half_v = rdata_i[{half_idx, 4'b0000} +: 16];
        sext   = ld_is_signed(ltype_i);
        case (ltype_i)
            LD_B, LD_BU: data_o = {{(DATA_W-8){sext & byte_v[7]}}, byte_v};
            LD_H, LD_HU: data_o = {{(DATA_W-16){sext & half_v[15]}}, half_v};
            default:     data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline of DEPTH stages with valid bits, stall/flush, load extension and write-back mux.
// Flush beats stall; register-0 and bubble writes are suppressed at the output.
module mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ValidIn,
    input  logic [DATA_W-1:0] ALUResultIn,
    input  logic [DATA_W-1:0] ReadDataDMIn,
    input  logic              MemToRegIn,
    input  logic              RegWriteIn,
    input  logic [RA_W-1:0]   WriteRegisterIn,
    input  logic [2:0]        LoadTypeIn,
    output logic              Valid,
    output logic [DATA_W-1:0] ALUResult,
    output logic [DATA_W-1:0] ReadDataDM,
    output logic              MemToReg,
    output logic              RegWrite,
    output logic [RA_W-1:0]   WriteRegister,
    output logic [DATA_W-1:0] WriteData
);

    localparam int LANE_W = $clog2(DATA_W / 8);

    stage_t            stage_q [DEPTH];
    stage_t            stage_d [DEPTH];
    stage_t            in_ent;
    stage_t            out_ent;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        in_ent          = '0;
        in_ent.valid    = ValidIn;
        in_ent.alu      = PKG_DATA_W'(ALUResultIn);
        in_ent.rdata    = PKG_DATA_W'(ReadDataDMIn);
        in_ent.memtoreg = MemToRegIn;
        in_ent.regwrite = RegWriteIn;
        in_ent.wreg     = PKG_RA_W'(WriteRegisterIn);
        in_ent.ltype    = LoadTypeIn;
    end

    always_comb begin
        stage_d[0] = in_ent;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (Flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end else if (Stall) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_ent = stage_q[DEPTH-1];

    load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .rdata_i (out_ent.rdata[DATA_W-1:0]),
        .lane_i  (out_ent.alu[LANE_W-1:0]),
        .ltype_i (out_ent.ltype),
        .data_o  (load_data)
    );

    assign Valid         = out_ent.valid;
    assign ALUResult     = out_ent.alu[DATA_W-1:0];
    assign ReadDataDM    = out_ent.rdata[DATA_W-1:0];
    assign MemToReg      = out_ent.memtoreg;
    assign WriteRegister = out_ent.wreg[RA_W-1:0];
    // Register 0 is hardwired; killing its write here keeps forwarding from seeing it.
    assign RegWrite      = out_ent.regwrite & out_ent.valid & (WriteRegister != '0);
    assign WriteData     = out_ent.memtoreg ? load_data : ALUResult;

endmodule
